mvm_row_sched: RTL

MVM_ROW_SCHED -- requirements
Module: mvm_row_sched

---
 rtl/mvm_pkg.sv | 21 ++
 rtl/mvm_row_sched.sv | 128 ++++++++++++
 2 files changed

// File: rtl/mvm_pkg.sv
// Shared definitions for the matrix-vector row scheduler: default sizes,
// element type and scheduler FSM states.
package mvm_pkg;

  localparam int MVM_N       = 8;  // element width
  localparam int MVM_S       = 8;  // elements per row (even)
  localparam int MVM_R       = 4;  // max rows per job
  localparam int MVM_ENG_LAT = 1;  // engine latency in cycles

  typedef logic [MVM_N-1:0] elem_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT,
    OUT,
    DONE
  } state_e;

endpackage

// File: rtl/mvm_row_sched.sv
// Row scheduler for an external MVM engine: fetches one weight row at a time,
// waits out the engine latency and streams each row result over a ready/valid port.
module mvm_row_sched
  import mvm_pkg::*;
#(
  parameter int N       = MVM_N,
  parameter int S       = MVM_S,
  parameter int R       = MVM_R,
  parameter int ENG_LAT = MVM_ENG_LAT
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   start,
  input  logic [$clog2(R+1)-1:0] row_count,
  input  logic [S*N-1:0]         u_in,
  output logic                   wmem_rd_en,
  output logic [$clog2(R)-1:0]   wmem_addr,
  input  logic [S*N-1:0]         wmem_rdata,
  output logic [S*N-1:0]         eng_w,
  output logic [S*N-1:0]         eng_u,
  input  logic [N-1:0]           eng_v,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [N-1:0]           res_data,
  output logic [$clog2(R)-1:0]   res_row,
  output logic                   busy,
  output logic                   done
);

  localparam int AW  = $clog2(R);
  localparam int CW  = $clog2(R + 1);
  localparam int WCW = $clog2(ENG_LAT + 2);

  state_e         state;
  logic [AW-1:0]  row_idx;
  logic [CW-1:0]  job_rows;
  logic [WCW-1:0] wait_cnt;
  logic           last_row;

  assign last_row = (CW'(row_idx) + CW'(1)) == job_rows;

  // NOTE: every register here is updated with <= so all state advances
  // together on the edge; blocking assignments would let later branches see
  // half-updated values.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= IDLE;
      row_idx    <= '0;
      job_rows   <= '0;
      wait_cnt   <= '0;
      wmem_rd_en <= 1'b0;
      wmem_addr  <= '0;
      eng_w      <= '0;
      eng_u      <= '0;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_row    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (row_count == '0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              eng_u      <= u_in;
              job_rows   <= (row_count > CW'(R)) ? CW'(R) : row_count;
              row_idx    <= '0;
              wmem_addr  <= '0;
              wmem_rd_en <= 1'b1;
              state      <= FETCH;
            end
          end
        end

        FETCH: begin
          wmem_rd_en <= 1'b0;
          state      <= LOAD;
        end

        LOAD: begin
          eng_w    <= wmem_rdata;
          wait_cnt <= '0;
          state    <= WAIT;
        end

        // Holds ENG_LAT+1 cycles so eng_v reflects the row loaded in LOAD.
        WAIT: begin
          if (wait_cnt == WCW'(ENG_LAT)) begin
            res_data  <= eng_v;
            res_row   <= row_idx;
            res_valid <= 1'b1;
            state     <= OUT;
          end else begin
            wait_cnt <= wait_cnt + WCW'(1);
          end
        end

        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (last_row) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              row_idx    <= row_idx + AW'(1);
              wmem_addr  <= row_idx + AW'(1);
              wmem_rd_en <= 1'b1;
              state      <= FETCH;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
